mf_clken_gen: RTL and testbench



---
 rtl/mf_clken_gen.sv | 102 ++++++++++
 tb/tb_mf_clken_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mf_clken_gen.sv
// rtl/mf_clken_gen.sv - multi-channel fractional clock-enable generator with lock flag
module mf_clken_gen #(
    parameter int NUM_CLKS    = 3,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic [ACC_W-1:0]    cfg_phase,
    input  logic                sync_restart,
    output logic [NUM_CLKS-1:0] clk_en,
    output logic [NUM_CLKS-1:0] active,
    output logic                locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES);

    typedef enum logic {
        SETTLE,
        LOCKED
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [ACC_W-1:0] inc_q   [NUM_CLKS];
    logic [ACC_W-1:0] phase_q [NUM_CLKS];
    logic [ACC_W-1:0] acc_q   [NUM_CLKS];

    logic accept;
    logic ch_ok;

    // An out-of-range channel still completes the handshake and disturbs lock.
    assign accept = cfg_valid & cfg_ready;
    assign ch_ok  = ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NUM_CLKS));

    // Per-channel accumulators, config storage, strobes and write throttle.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                inc_q[i]   <= '0;
                phase_q[i] <= '0;
                acc_q[i]   <= '0;
            end
            clk_en    <= '0;
            active    <= '0;
            cfg_ready <= 1'b1;
        end else begin
            // Ready drops for the single cycle following any accepted write.
            cfg_ready <= ~accept;
            for (int i = 0; i < NUM_CLKS; i++) begin
                if (accept && ch_ok && (cfg_ch == CH_W'(i))) begin
                    inc_q[i]   <= cfg_inc;
                    phase_q[i] <= cfg_phase;
                    acc_q[i]   <= cfg_phase;
                    clk_en[i]  <= 1'b0;
                    active[i]  <= (cfg_inc != '0);
                end else if (sync_restart) begin
                    acc_q[i]  <= phase_q[i];
                    clk_en[i] <= 1'b0;
                end else begin
                    {clk_en[i], acc_q[i]} <= {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
                end
            end
        end
    end

    // Lock FSM state and settle counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= SETTLE;
            cnt   <= CNT_INIT;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Any config write or restart re-arms the settle window; otherwise count down to lock.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept || sync_restart) begin
            state_nx = SETTLE;
            cnt_nx   = CNT_INIT;
        end else if (state == SETTLE) begin
            cnt_nx = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                state_nx = LOCKED;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_mf_clken_gen.sv
// tb/tb_mf_clken_gen.sv - randomized self-checking bench for mf_clken_gen
module tb_mf_clken_gen;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int LC = 16;

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_ch = '0;
    logic [W-1:0] cfg_inc = '0;
    logic [W-1:0] cfg_phase = '0;
    logic         sync_restart = 1'b0;
    logic [N-1:0] clk_en;
    logic [N-1:0] active;
    logic         locked;

    mf_clken_gen #(.NUM_CLKS(N), .ACC_W(W), .LOCK_CYCLES(LC)) dut (
        .refclk(refclk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc),
        .cfg_phase(cfg_phase),
        .sync_restart(sync_restart),
        .clk_en(clk_en),
        .active(active),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each channel strobes whenever floor((base + k*inc) / 2^W)
    // increments, k counting edges since the channel was last (re)loaded.
    longint unsigned m_inc   [N];
    longint unsigned m_phase [N];
    longint unsigned m_base  [N];
    longint unsigned m_k     [N];
    logic [N-1:0]    m_en;
    logic [N-1:0]    m_act;
    logic            m_ready;
    int              m_since;

    int strobes;
    int accepts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic acc_w, wr;
        longint unsigned a, b;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_inc[i] = 0; m_phase[i] = 0; m_base[i] = 0; m_k[i] = 0;
            end
            m_en = '0; m_act = '0; m_ready = 1'b1; m_since = 0;
            return;
        end
        acc_w = cfg_valid && m_ready;
        wr    = acc_w && (cfg_ch < 2'(N));
        for (int i = 0; i < N; i++) begin
            if (wr && (int'(cfg_ch) == i)) begin
                m_inc[i] = cfg_inc; m_phase[i] = cfg_phase; m_base[i] = cfg_phase;
                m_k[i] = 0; m_en[i] = 1'b0; m_act[i] = (cfg_inc != 0);
            end else if (sync_restart) begin
                m_base[i] = m_phase[i]; m_k[i] = 0; m_en[i] = 1'b0;
            end else begin
                m_k[i]++;
                a = m_base[i] + m_k[i] * m_inc[i];
                b = a - m_inc[i];
                m_en[i] = ((a >> W) != (b >> W));
            end
        end
        m_ready = !acc_w;
        if (acc_w || sync_restart) m_since = 0;
        else if (m_since < 1000) m_since++;
    endtask

    task automatic cycle();
        @(posedge refclk);
        model_step();
        #1;
        chk("clk_en", 32'(clk_en), 32'(m_en));
        chk("active", 32'(active), 32'(m_act));
        chk("locked", 32'(locked), 32'(m_since >= LC));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write(input logic [1:0] ch, input logic [W-1:0] inc, input logic [W-1:0] ph);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_phase = ph;
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset, then lock with everything idle.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(20);

        // Quarter-rate channel 0: exactly 100 strobes in 400 cycles after the write.
        write(2'd0, 16'd16384, 16'd0);
        strobes = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            strobes += int'(clk_en[0]);
        end
        chk("ch0_strobe_count", 32'(strobes), 32'd100);

        // Half-cycle phase offset on channel 1, aligned by a common restart.
        write(2'd1, 16'd16384, 16'd32768);
        cycle();
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        idle(24);

        // cfg_valid held for 6 cycles: only every other cycle is accepted.
        accepts = 0;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 16'd21845; cfg_phase = 16'd100;
        for (int i = 0; i < 6; i++) begin
            accepts += int'(cfg_ready);
            cycle();
        end
        cfg_valid = 1'b0;
        chk("held_valid_accepts", 32'(accepts), 32'd3);
        idle(20);

        // Out-of-range channel: handshake only, lock dropped.
        write(2'd3, 16'd1234, 16'd4321);
        idle(20);

        // Restart coinciding with a write to channel 2.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 16'd21845; cfg_phase = 16'd60000;
        sync_restart = 1'b1;
        cycle();
        cfg_valid = 1'b0; sync_restart = 1'b0;
        idle(30);

        // Near-full rate on channel 0, fractional on channel 2.
        write(2'd0, 16'd65535, 16'd0);
        idle(1000);

        // Reset while locked with strobes running.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        idle(20);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            cfg_valid    = ($urandom_range(0, 9) == 0);
            cfg_ch       = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cfg_inc = '0;
                1:       cfg_inc = 16'hFFFF;
                default: cfg_inc = 16'($urandom);
            endcase
            cfg_phase    = 16'($urandom);
            sync_restart = ($urandom_range(0, 49) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            cycle();
        end
        cfg_valid = 1'b0; sync_restart = 1'b0; rst = 1'b0;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
